// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus I/O space (UART RX, TX FIFO, cycle counter, program stop)
module mem_io_responder #(
  parameter int ADDR_WIDTH  = 17,
  parameter int TXQ_DEPTH   = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        halted,
  output logic        overflow
);
  localparam int PW = $clog2(TXQ_DEPTH);
  typedef enum logic [1:0] {RUN, STOPPING, HALTED} state_t;
  state_t            r_state;
  logic [7:0]        r_ram [2**ADDR_WIDTH];
  logic [7:0]        r_fifo [TXQ_DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [PW:0]       r_count, w_next_count;
  logic [31:0]       r_cnt, r_snap;
  logic [15:0]       w_reg;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [7:0]        w_rdata, w_pdata;
  logic w_io, w_rd, w_wr_ok, w_io_wr, w_push_stop, w_push, w_pop, w_full, w_push_ok;
  logic w_unused;
  assign w_unused    = ^mem_a[31:18];
  assign w_io        = mem_a[17:16] == 2'b11;
  assign w_reg       = mem_a[15:0];
  assign w_idx       = mem_a[ADDR_WIDTH-1:0];
  assign w_rd        = !mem_wr;
  assign w_wr_ok     = mem_wr && r_state != HALTED;
  assign w_io_wr     = w_wr_ok && w_io && r_state == RUN;
  assign w_push_stop = w_io_wr && w_reg == 16'h0004;
  assign w_push      = w_push_stop || (w_io_wr && w_reg == 16'h0000 && mem_dout != 8'h00);
  assign w_pdata     = w_push_stop ? 8'h00 : mem_dout;
  assign tx_valid    = r_count != '0;
  assign tx_data     = r_fifo[r_rp];
  assign w_pop       = tx_valid && tx_ready;
  assign w_full      = r_count == (PW+1)'(TXQ_DEPTH);
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign w_push_ok    = w_push && (!w_full || w_pop);
  assign w_next_count = r_count + (PW+1)'(w_push_ok) - (PW+1)'(w_pop);
  assign w_rdata = !w_io               ? r_ram[w_idx] :
                   w_reg == 16'h0000   ? (rx_valid ? rx_data : 8'h00) :
                   w_reg == 16'h0004   ? r_cnt[7:0] :
                   w_reg == 16'h0005   ? r_snap[15:8] :
                   w_reg == 16'h0006   ? r_snap[23:16] :
                   w_reg == 16'h0007   ? r_snap[31:24] : 8'h00;
  always_ff @(posedge clk_in) begin
    if (w_wr_ok && !w_io) r_ram[w_idx] <= mem_dout;
    if (w_push_ok) r_fifo[r_wp] <= w_pdata;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_din        <= 8'h00;
      io_buffer_full <= 1'b0;
      rx_pop         <= 1'b0;
      halted         <= 1'b0;
      overflow       <= 1'b0;
      r_state        <= RUN;
      r_wp           <= '0;
      r_rp           <= '0;
      r_count        <= '0;
      r_cnt          <= '0;
      r_snap         <= '0;
    end else begin
      r_cnt          <= r_cnt + 32'd1;
      mem_din        <= w_rd ? w_rdata : mem_din;
      rx_pop         <= w_rd && w_io && w_reg == 16'h0000 && rx_valid;
      r_snap         <= (w_rd && w_io && w_reg == 16'h0004) ? r_cnt : r_snap;
      overflow       <= overflow || (w_push && !w_push_ok);
      r_wp           <= w_push_ok ? r_wp + PW'(1) : r_wp;
      r_rp           <= w_pop ? r_rp + PW'(1) : r_rp;
      r_count        <= w_next_count;
      io_buffer_full <= (TXQ_DEPTH - 32'(w_next_count)) <= FULL_MARGIN;
      // no pushes are accepted while stopping, so an empty FIFO means the marker left
      r_state        <= (r_state == RUN && w_push_stop) ? STOPPING :
                        (r_state == STOPPING && w_next_count == '0) ? HALTED : r_state;
      halted         <= r_state == HALTED || (r_state == STOPPING && w_next_count == '0);
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed steps with scoreboard queues for read data and TX bytes
module tb_mem_io_responder;
  logic        clk_in = 1'b0, rst_n_in = 1'b0;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0, mem_din, tx_data, rx_data = '0;
  logic        mem_wr = 1'b0, io_buffer_full, tx_valid, tx_ready = 1'b0, rx_valid = 1'b0;
  logic        rx_pop, halted, overflow;
  int          checks = 0, failures = 0, cyc = 0;
  logic [7:0]  rd_q[$], tx_q[$];

  mem_io_responder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_pop(rx_pop), .halted(halted), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) if (rst_n_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_in)
    if (rst_n_in && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) check("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else check("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
    end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    mem_wr = 1'b0;
    mem_a  = 32'h10;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_wr = 1'b1; mem_a = a; mem_dout = d;
    tick();
    idle();
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [7:0] exp);
    mem_wr = 1'b0; mem_a = a;
    rd_q.push_back(exp);
    tick();
    check(tag, {24'h0, mem_din}, {24'h0, rd_q.pop_front()});
    idle();
  endtask

  initial begin
    #3;
    check("rst_mem_din", {24'h0, mem_din}, 0);
    check("rst_flags", {27'h0, io_buffer_full, tx_valid, rx_pop, halted, overflow}, 0);
    tick();
    rst_n_in = 1'b1;
    idle();
    // T1: RAM write then read, top address, write cycle keeps mem_din
    wr(32'h10, 8'hA5);
    rd("t1_ram", 32'h10, 8'hA5);
    wr(32'h1FFFF, 8'h3C);
    rd("t1_top", 32'h1FFFF, 8'h3C);
    wr(32'h0, 8'h11);
    check("t1_wr_hold", {24'h0, mem_din}, 32'h3C);
    rd("t1_zero", 32'h0, 8'h11);
    // T2: zero byte not queued
    tx_ready = 1'b1;
    wr(32'h30000, 8'h41); tx_q.push_back(8'h41);
    wr(32'h30000, 8'h00);
    wr(32'h30000, 8'h42); tx_q.push_back(8'h42);
    repeat (3) tick();
    check("t2_drained", {31'h0, tx_valid}, 0);
    check("t2_no_ovf", {31'h0, overflow}, 0);
    check("t2_q_empty", tx_q.size(), 0);
    // T3: fill FIFO with TX stalled
    tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      wr(32'h30000, 8'(i)); tx_q.push_back(8'(i));
      if (i == 5) check("t3_not_full5", {31'h0, io_buffer_full}, 0);
      if (i == 6) check("t3_full6", {31'h0, io_buffer_full}, 1);
    end
    check("t3_no_ovf8", {31'h0, overflow}, 0);
    wr(32'h30000, 8'h09);
    check("t3_ovf9", {31'h0, overflow}, 1);
    tx_ready = 1'b1;
    wr(32'h30000, 8'h0A); tx_q.push_back(8'h0A);
    check("t3_full_pushpop", {31'h0, io_buffer_full}, 1);
    repeat (10) tick();
    check("t3_q_empty", tx_q.size(), 0);
    check("t3_full_clear", {31'h0, io_buffer_full}, 0);
    check("t3_ovf_sticky", {31'h0, overflow}, 1);
    // T5: RX byte read and pop pulse
    rx_valid = 1'b1; rx_data = 8'h7E;
    rd("t5_rx", 32'h30000, 8'h7E);
    check("t5_pop", {31'h0, rx_pop}, 1);
    rx_valid = 1'b0;
    rd("t5_rx_none", 32'h30000, 8'h00);
    check("t5_pop_once", {31'h0, rx_pop}, 0);
    rd("t5_other_io", 32'h30010, 8'h00);
    // T4: counter snapshot at cycle 0x123
    if (cyc > 32'h123) check("t4_too_late", cyc, 32'h123);
    while (cyc < 32'h123) tick();
    rd("t4_b0", 32'h30004, 8'h23);
    tick();
    rd("t4_b1", 32'h30005, 8'h01);
    rd("t4_b2", 32'h30006, 8'h00);
    rd("t4_b3", 32'h30007, 8'h00);
    begin
      logic [31:0] c;
      c = cyc;
      rd("t4_resnap", 32'h30004, c[7:0]);
    end
    // T6: stop marker, drain, halt
    tx_ready = 1'b0;
    wr(32'h30000, 8'h55); tx_q.push_back(8'h55);
    wr(32'h30004, 8'hFF); tx_q.push_back(8'h00);
    wr(32'h30000, 8'h66);
    repeat (5) tick();
    check("t6_not_halted", {31'h0, halted}, 0);
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && !halted; i++) tick();
    check("t6_halted", {31'h0, halted}, 1);
    check("t6_q_empty", tx_q.size(), 0);
    wr(32'h0, 8'hEE);
    rd("t6_ram_locked", 32'h0, 8'h11);
    wr(32'h30000, 8'h77);
    check("t6_io_locked", {31'h0, tx_valid}, 0);
    #2 rst_n_in = 1'b0;
    #1 check("t6_async_rst", {30'h0, halted, mem_din != 0}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
